fp_div_seq: RTL and testbench
=============================

# fp_div_seq

Iterative sequencer for floating-point division in half (binary16) or single (binary32) format. It latches operand fields on a start handshake and screens special operands. Finite quotients are produced by restoring division, one quotient bit per clock. The block then normalizes, checks exponent range and presents sign/exponent/fraction plus IEEE-style exception flags with a one-cycle done pulse. It sits beside the combinational exponent/sign/flag logic in the FP unit and is the block the ALU controller talks to for DIV operations.

## Interface
- No parameters; both formats are selected at run time by MODE_FP.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- MODE_FP  in  1  0 = half, 1 = single; latched with start
- SIGN_A, SIGN_B  in  1  operand signs
- EXP_A, EXP_B  in  8  biased exponents (half uses [4:0], upper bits ignored)
- MANT_A, MANT_B  in  23  fractions (half uses [9:0], upper bits ignored)
- busy  out  1  high from the cycle after start is accepted through the NORM state
- done  out  1  one-cycle pulse, result valid
- sign  out  1  result sign
- exp  out  9  result biased exponent
- mant  out  23  result fraction, truncated (half: [9:0], [22:10] = 0)
- FLAGS  out  5  [0] inexact, [1] invalid, [2] divide-by-zero, [3] underflow, [4] overflow

## Operation
- States: IDLE, CHECK, DIVIDE, NORM, DONE. start is accepted in IDLE or DONE.
- Accept: latch all inputs. Go to CHECK.
- Format constants:
  - Single: F=23, bias 127, MAX 254, all-ones exponent 255.
  - Half: F=10, bias 15, MAX 30, all-ones exponent 31.
- Denormal inputs (exponent 0) are treated as signed zero.
- CHECK classifies operands and resolves special cases, in priority order. All special results go directly to DONE.
  - Either operand NaN (all-ones exponent, fraction ≠ 0), 0/0, or inf/inf: quiet NaN (exp all-ones, mant MSB of fraction set), sign 0, FLAGS[1].
  - Finite nonzero / 0: inf, FLAGS[2].
  - inf/finite: inf. 0/nonzero or finite/inf: zero (exp 0, mant 0). No flags for either.
  - Otherwise: load dividend {1,fracA}, divisor {1,fracB} and counter K, then go to DIVIDE.
  - K = F+3: 26 for single, 13 for half.
  - Precompute e = EXP_A − EXP_B + bias as 10-bit signed.
- DIVIDE performs one restoring step per cycle.
  - Step: R' = 2R − D. If R' ≥ 0 then q bit = 1 and R = R'; else q bit = 0.
  - The first step compares the undoubled dividend: the quotient has weight 2^0 at bit K−1.
  - Shift q left one bit per cycle. Leave DIVIDE when K bits are done.
- NORM:
  - If q[K−1] = 1: fraction = q[K−2 −: F].
  - Else: fraction = q[K−3 −: F] and e = e − 1.
  - inexact = any discarded q bit set OR remainder ≠ 0.
  - e > MAX: overflow. Result inf (exp all-ones, mant 0), FLAGS[4] and FLAGS[0].
  - e < 1: underflow. Result signed zero, FLAGS[3] and FLAGS[0].
  - Otherwise exp = e[8:0].
- sign = SIGN_A ^ SIGN_B for every result except NaN.

## Timing
- Reset: state IDLE, busy 0, done 0, sign 0, exp 0, mant 0, FLAGS 0. Any in-flight operation is discarded.
- Latency counts from the edge that samples start (cycle 0):
  - Special case: done high in cycle 2.
  - Finite single: done high in cycle K+3 = 29.
  - Finite half: done high in cycle K+3 = 16.
- Result outputs update on the edge that enters DONE. They hold until the next result.
- done is high only in DONE, for exactly one cycle. DONE returns to IDLE unless start is high.
- start while busy=1 is ignored, with no queueing.
- start during DONE is accepted: back-to-back operation with zero idle cycles.
- rst high together with start: reset wins.

## Test plan
- Single 6.0/2.0 (EXP_A 129, MANT_A 0x400000, EXP_B 128, MANT_B 0): done in cycle 29, sign 0, exp 128, mant 0x400000, FLAGS 0.
- Single 1.0/3.0 (EXP_A 127 frac 0; EXP_B 128 frac 0x400000): exp 125, mant 0x2AAAAA, FLAGS 5'b00001.
- Half 1.0/0 (EXP_A 15, B all zero): done in cycle 2, exp 31, mant 0, FLAGS 5'b00100. Half 0/0: exp 31, mant[9] = 1, FLAGS 5'b00010.
- Single overflow EXP_A 254 / EXP_B 1, fractions 0: exp 255, mant 0, FLAGS 5'b10001. Reverse (EXP_A 1 / EXP_B 254): exp 0, mant 0, FLAGS 5'b01001.
- Handshake:
  - start pulsed at cycle 5 of a running operation is ignored; the result matches a single operation.
  - start held during DONE launches a second divide, whose done arrives exactly 29 cycles later.
- rst at cycle 10 of a single divide: the next cycle has busy 0, done never pulses, and all outputs are 0. A following 6.0/2.0 completes normally.

Source files
------------

// File: rtl/fp_div_seq.sv
// Sequential binary16/binary32 divider: special-operand screening, restoring
// division one quotient bit per clock, normalisation and exponent range check.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        MODE_FP,
  input  logic        SIGN_A,
  input  logic        SIGN_B,
  input  logic [7:0]  EXP_A,
  input  logic [7:0]  EXP_B,
  input  logic [22:0] MANT_A,
  input  logic [22:0] MANT_B,
  output logic        busy,
  output logic        done,
  output logic        sign,
  output logic [8:0]  exp,
  output logic [22:0] mant,
  output logic [4:0]  FLAGS
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_DIVIDE = 3'd2,
    S_NORM   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        mode_q, mode_d, sa_q, sa_d, sb_q, sb_d;
  logic [7:0]  ea_q, ea_d, eb_q, eb_d;
  logic [22:0] ma_q, ma_d, mb_q, mb_d;
  logic [25:0] rem_q, rem_d, quo_q, quo_d;
  logic [23:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        first_q, first_d;
  logic [9:0]  e_q, e_d;
  logic        busy_q, busy_d, done_q, done_d, sign_q, sign_d;
  logic [8:0]  exp_q, exp_d;
  logic [22:0] mant_q, mant_d;
  logic [4:0]  flags_q, flags_d;

  logic        accept_s;
  logic [7:0]  ea_s, eb_s, ones_s;
  logic [22:0] ma_s, mb_s, qnan_s;
  logic [23:0] siga_s, sigb_s;
  logic [9:0]  bias_s, max_s, e_calc_s, e_norm_s;
  logic [4:0]  k_s;
  logic        a_zero_s, a_inf_s, a_nan_s, b_zero_s, b_inf_s, b_nan_s;
  logic [25:0] shifted_s, diff_s;
  logic        ge_s;
  logic [22:0] frac_s;
  logic        lost_s, ovf_s, unf_s;

  // Format-dependent views of the latched operands
  always_comb begin
    if (mode_q) begin
      ea_s   = ea_q;
      eb_s   = eb_q;
      ma_s   = ma_q;
      mb_s   = mb_q;
      siga_s = {1'b1, ma_q};
      sigb_s = {1'b1, mb_q};
      ones_s = 8'd255;
      qnan_s = 23'h400000;
      bias_s = 10'd127;
      max_s  = 10'd254;
      k_s    = 5'd26;
    end else begin
      ea_s   = {3'b000, ea_q[4:0]};
      eb_s   = {3'b000, eb_q[4:0]};
      ma_s   = {13'd0, ma_q[9:0]};
      mb_s   = {13'd0, mb_q[9:0]};
      siga_s = {13'd0, 1'b1, ma_q[9:0]};
      sigb_s = {13'd0, 1'b1, mb_q[9:0]};
      ones_s = 8'd31;
      qnan_s = 23'h000200;
      bias_s = 10'd15;
      max_s  = 10'd30;
      k_s    = 5'd13;
    end
  end

  assign a_zero_s = (ea_s == 8'd0);
  assign b_zero_s = (eb_s == 8'd0);
  assign a_nan_s  = (ea_s == ones_s) && (ma_s != 23'd0);
  assign b_nan_s  = (eb_s == ones_s) && (mb_s != 23'd0);
  assign a_inf_s  = (ea_s == ones_s) && (ma_s == 23'd0);
  assign b_inf_s  = (eb_s == ones_s) && (mb_s == 23'd0);
  assign e_calc_s = {2'b00, ea_s} - {2'b00, eb_s} + bias_s;
  assign accept_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // The first restoring step compares the undoubled dividend (weight 2^0)
  assign shifted_s = first_q ? rem_q : {rem_q[24:0], 1'b0};
  assign diff_s    = shifted_s - {2'b00, dvs_q};
  assign ge_s      = (shifted_s >= {2'b00, dvs_q});

  // Normalise the quotient: leading bit at K-1 or K-2
  always_comb begin
    if (mode_q) begin
      if (quo_q[25]) begin
        frac_s   = quo_q[24:2];
        lost_s   = |quo_q[1:0];
        e_norm_s = e_q;
      end else begin
        frac_s   = quo_q[23:1];
        lost_s   = quo_q[0];
        e_norm_s = e_q - 10'd1;
      end
    end else begin
      if (quo_q[12]) begin
        frac_s   = {13'd0, quo_q[11:2]};
        lost_s   = |quo_q[1:0];
        e_norm_s = e_q;
      end else begin
        frac_s   = {13'd0, quo_q[10:1]};
        lost_s   = quo_q[0];
        e_norm_s = e_q - 10'd1;
      end
    end
  end

  assign ovf_s = $signed(e_norm_s) > $signed(max_s);
  assign unf_s = $signed(e_norm_s) < $signed(10'sd1);

  // Next-state, datapath and result selection
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;  sa_d = sa_q;  sb_d = sb_q;
    ea_d    = ea_q;    eb_d = eb_q;  ma_d = ma_q;  mb_d = mb_q;
    rem_d   = rem_q;   quo_d = quo_q; dvs_d = dvs_q;
    cnt_d   = cnt_q;   first_d = first_q; e_d = e_q;
    sign_d  = sign_q;  exp_d = exp_q; mant_d = mant_q; flags_d = flags_q;
    if (accept_s) begin
      mode_d  = MODE_FP;
      sa_d    = SIGN_A;
      sb_d    = SIGN_B;
      ea_d    = EXP_A;
      eb_d    = EXP_B;
      ma_d    = MANT_A;
      mb_d    = MANT_B;
      state_d = S_CHECK;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_CHECK: begin
          state_d = S_DONE;
          sign_d  = sa_q ^ sb_q;
          exp_d   = 9'd0;
          mant_d  = 23'd0;
          flags_d = 5'b00000;
          if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            sign_d  = 1'b0;
            exp_d   = {1'b0, ones_s};
            mant_d  = qnan_s;
            flags_d = 5'b00010;
          end else if (!a_zero_s && !a_inf_s && b_zero_s) begin
            exp_d   = {1'b0, ones_s};
            flags_d = 5'b00100;
          end else if (a_inf_s) begin
            exp_d   = {1'b0, ones_s};
          end else if (a_zero_s || b_inf_s) begin
            exp_d   = 9'd0;
          end else begin
            sign_d  = sign_q;
            exp_d   = exp_q;
            mant_d  = mant_q;
            flags_d = flags_q;
            rem_d   = {2'b00, siga_s};
            dvs_d   = sigb_s;
            quo_d   = 26'd0;
            cnt_d   = k_s;
            first_d = 1'b1;
            e_d     = e_calc_s;
            state_d = S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          quo_d   = {quo_q[24:0], ge_s};
          rem_d   = ge_s ? diff_s : shifted_s;
          first_d = 1'b0;
          cnt_d   = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = S_NORM;
          end else begin
            state_d = S_DIVIDE;
          end
        end
        S_NORM: begin
          state_d = S_DONE;
          sign_d  = sa_q ^ sb_q;
          if (ovf_s) begin
            exp_d   = {1'b0, ones_s};
            mant_d  = 23'd0;
            flags_d = 5'b10001;
          end else if (unf_s) begin
            exp_d   = 9'd0;
            mant_d  = 23'd0;
            flags_d = 5'b01001;
          end else begin
            exp_d   = e_norm_s[8:0];
            mant_d  = frac_s;
            flags_d = {4'b0000, lost_s | (rem_q != 26'd0)};
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_CHECK) || (state_d == S_DIVIDE) || (state_d == S_NORM);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;  sa_q <= 1'b0;  sb_q <= 1'b0;
      ea_q    <= 8'd0;  eb_q <= 8'd0;  ma_q <= 23'd0; mb_q <= 23'd0;
      rem_q   <= 26'd0; quo_q <= 26'd0; dvs_q <= 24'd0;
      cnt_q   <= 5'd0;  first_q <= 1'b0; e_q <= 10'd0;
      busy_q  <= 1'b0;  done_q <= 1'b0; sign_q <= 1'b0;
      exp_q   <= 9'd0;  mant_q <= 23'd0; flags_q <= 5'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;  sa_q <= sa_d;  sb_q <= sb_d;
      ea_q    <= ea_d;    eb_q <= eb_d;  ma_q <= ma_d;  mb_q <= mb_d;
      rem_q   <= rem_d;   quo_q <= quo_d; dvs_q <= dvs_d;
      cnt_q   <= cnt_d;   first_q <= first_d; e_q <= e_d;
      busy_q  <= busy_d;  done_q <= done_d; sign_q <= sign_d;
      exp_q   <= exp_d;   mant_q <= mant_d; flags_q <= flags_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sign  = sign_q;
  assign exp   = exp_q;
  assign mant  = mant_q;
  assign FLAGS = flags_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: directed test-plan cases plus random
// operands checked against an integer-arithmetic reference model.
module tb_fp_div_seq;
  logic        clk = 1'b0;
  logic        rst, start, MODE_FP, SIGN_A, SIGN_B;
  logic [7:0]  EXP_A, EXP_B;
  logic [22:0] MANT_A, MANT_B;
  logic        busy, done, sign;
  logic [8:0]  exp;
  logic [22:0] mant;
  logic [4:0]  FLAGS;

  always #5 clk = ~clk;

  fp_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .MODE_FP(MODE_FP),
    .SIGN_A(SIGN_A), .SIGN_B(SIGN_B), .EXP_A(EXP_A), .EXP_B(EXP_B),
    .MANT_A(MANT_A), .MANT_B(MANT_B), .busy(busy), .done(done),
    .sign(sign), .exp(exp), .mant(mant), .FLAGS(FLAGS)
  );

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [22:0] mant;
    logic [4:0]  flags;
  } res_t;

  typedef struct {
    res_t    r;
    longint  t_due;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: classify, then divide significands as plain integers
  function automatic void model(input logic mode, input logic sa, input logic sb_in,
                                input logic [7:0] ea_in, input logic [7:0] eb_in,
                                input logic [22:0] ma_in, input logic [22:0] mb_in,
                                output res_t r, output int lat);
    int f, bias, maxe, ones, ea, eb, k, e;
    longint unsigned ma, mb, num, den, q, rm, frac, lost, fmask;
    bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    f    = mode ? 23 : 10;
    bias = mode ? 127 : 15;
    maxe = mode ? 254 : 30;
    ones = mode ? 255 : 31;
    ea   = mode ? int'(ea_in) : int'(ea_in[4:0]);
    eb   = mode ? int'(eb_in) : int'(eb_in[4:0]);
    fmask = (64'd1 << f) - 64'd1;
    ma   = longint'(ma_in) & fmask;
    mb   = longint'(mb_in) & fmask;
    nan_a = (ea == ones) && (ma != 0);
    nan_b = (eb == ones) && (mb != 0);
    inf_a = (ea == ones) && (ma == 0);
    inf_b = (eb == ones) && (mb == 0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    r.sign = sa ^ sb_in;
    r.exp = 9'd0;
    r.mant = 23'd0;
    r.flags = 5'd0;
    lat = 2;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      r.sign = 1'b0;
      r.exp = 9'(ones);
      r.mant = 23'(64'd1 << (f - 1));
      r.flags = 5'b00010;
    end else if (!zero_a && !inf_a && zero_b) begin
      r.exp = 9'(ones);
      r.flags = 5'b00100;
    end else if (inf_a) begin
      r.exp = 9'(ones);
    end else if (zero_a || inf_b) begin
      r.exp = 9'd0;
    end else begin
      k = f + 3;
      lat = k + 3;
      num = ((64'd1 << f) | ma) << (k - 1);
      den = (64'd1 << f) | mb;
      q = num / den;
      rm = num % den;
      e = ea - eb + bias;
      if (q >= (64'd1 << (k - 1))) begin
        frac = (q >> 2) & fmask;
        lost = q & 64'd3;
      end else begin
        frac = (q >> 1) & fmask;
        lost = q & 64'd1;
        e = e - 1;
      end
      if (e > maxe) begin
        r.exp = 9'(ones);
        r.flags = 5'b10001;
      end else if (e < 1) begin
        r.flags = 5'b01001;
      end else begin
        r.exp = 9'(e);
        r.mant = 23'(frac);
        r.flags = {4'b0000, (lost != 0) || (rm != 0)};
      end
    end
  endfunction

  // Monitor: every done pulse must match the oldest expectation, on time
  always @(negedge clk) begin
    item_t it;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done at %0t", $time);
      end else begin
        it = sb.pop_front();
        check("result", {26'd0, sign, exp, mant, FLAGS}, {26'd0, it.r});
        check("latency", 64'($time), 64'(it.t_due));
      end
    end
  end

  // Drive one request (caller sits at a negedge); expectation pushed at the sampling edge
  task automatic issue(input logic mode, input logic sa, input logic sbv,
                       input logic [7:0] ea, input logic [7:0] eb,
                       input logic [22:0] ma, input logic [22:0] mb);
    item_t it;
    int lat;
    MODE_FP = mode; SIGN_A = sa; SIGN_B = sbv;
    EXP_A = ea; EXP_B = eb; MANT_A = ma; MANT_B = mb;
    start = 1'b1;
    @(posedge clk);
    model(mode, sa, sbv, ea, eb, ma, mb, it.r, lat);
    it.t_due = longint'($time) + 10 * lat - 5;
    sb.push_back(it);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 60);
    check({name, "_done_seen"}, 64'(done === 1'b1), 64'd1);
  endtask

  task automatic run(input string name, input logic mode, input logic sa, input logic sbv,
                     input logic [7:0] ea, input logic [7:0] eb,
                     input logic [22:0] ma, input logic [22:0] mb);
    issue(mode, sa, sbv, ea, eb, ma, mb);
    wait_done(name);
    @(negedge clk);
  endtask

  function automatic logic [7:0] rexp(input logic mode);
    logic [7:0] v;
    v = 8'($urandom);
    case ($urandom_range(7))
      0: v = mode ? 8'd0 : {v[7:5], 5'd0};
      1: v = mode ? 8'd255 : {v[7:5], 5'd31};
      2: v = v;
      default: v = mode ? 8'($urandom_range(100, 154)) : {v[7:5], 5'($urandom_range(6, 24))};
    endcase
    return v;
  endfunction

  function automatic logic [22:0] rmant();
    logic [22:0] v;
    v = 23'($urandom);
    if ($urandom_range(7) == 0) v = 23'd0;
    return v;
  endfunction

  initial begin
    int seen;
    longint t1;
    logic m;
    rst = 1'b1; start = 1'b0; MODE_FP = 1'b0; SIGN_A = 1'b0; SIGN_B = 1'b0;
    EXP_A = 8'd0; EXP_B = 8'd0; MANT_A = 23'd0; MANT_B = 23'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {25'd0, busy, done, sign, exp, mant, FLAGS}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run("s_6div2", 1'b1, 1'b0, 1'b0, 8'd129, 8'd128, 23'h400000, 23'h0);
    check("s_6div2_val", {26'd0, sign, exp, mant, FLAGS}, {26'd0, 1'b0, 9'd128, 23'h400000, 5'b00000});
    run("s_1div3", 1'b1, 1'b0, 1'b0, 8'd127, 8'd128, 23'h0, 23'h400000);
    check("s_1div3_val", {26'd0, sign, exp, mant, FLAGS}, {26'd0, 1'b0, 9'd125, 23'h2AAAAA, 5'b00001});
    run("h_1div0", 1'b0, 1'b0, 1'b0, 8'd15, 8'd0, 23'h0, 23'h0);
    check("h_1div0_val", {26'd0, exp, mant, FLAGS}, {26'd0, 1'b0, 9'd31, 23'h0, 5'b00100});
    run("h_0div0", 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 23'h0, 23'h0);
    check("h_0div0_val", {26'd0, sign, exp, mant, FLAGS}, {26'd0, 1'b0, 9'd31, 23'h200, 5'b00010});
    run("s_ovf", 1'b1, 1'b1, 1'b0, 8'd254, 8'd1, 23'h0, 23'h0);
    check("s_ovf_val", {26'd0, sign, exp, mant, FLAGS}, {26'd0, 1'b1, 9'd255, 23'h0, 5'b10001});
    run("s_unf", 1'b1, 1'b0, 1'b0, 8'd1, 8'd254, 23'h0, 23'h0);
    check("s_unf_val", {26'd0, exp, mant, FLAGS}, {26'd0, 9'd0, 23'h0, 5'b01001});
    run("s_infdiv", 1'b1, 1'b0, 1'b1, 8'd255, 8'd130, 23'h0, 23'h1234);
    run("s_divinf", 1'b1, 1'b0, 1'b0, 8'd130, 8'd255, 23'h1, 23'h0);
    run("h_nan", 1'b0, 1'b1, 1'b1, 8'd31, 8'd15, 23'h1, 23'h0);

    // start mid-operation is ignored
    issue(1'b1, 1'b0, 1'b0, 8'd129, 8'd128, 23'h400000, 23'h0);
    repeat (3) @(negedge clk);
    MODE_FP = 1'b0; EXP_A = 8'd20; EXP_B = 8'd0; MANT_A = 23'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored_start");
    repeat (2) @(negedge clk);
    check("ignored_start_idle", 64'(busy), 64'd0);

    // back-to-back: start held while done is high
    issue(1'b1, 1'b0, 1'b0, 8'd127, 8'd128, 23'h0, 23'h400000);
    wait_done("b2b_first");
    t1 = longint'($time);
    issue(1'b1, 1'b0, 1'b0, 8'd129, 8'd128, 23'h400000, 23'h0);
    wait_done("b2b_second");
    check("b2b_spacing", 64'(longint'($time) - t1), 64'd290);
    @(negedge clk);

    // reset in the middle of a single divide
    issue(1'b1, 1'b0, 1'b0, 8'd129, 8'd128, 23'h400000, 23'h0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_outputs", {25'd0, busy, done, sign, exp, mant, FLAGS}, 64'd0);
    rst = 1'b0;
    seen = 0;
    repeat (35) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("midrst_no_done", 64'(seen), 64'd0);
    run("after_rst", 1'b1, 1'b0, 1'b0, 8'd129, 8'd128, 23'h400000, 23'h0);
    check("after_rst_val", {26'd0, sign, exp, mant, FLAGS}, {26'd0, 1'b0, 9'd128, 23'h400000, 5'b00000});

    // reset and start on the same edge
    rst = 1'b1; start = 1'b1; MODE_FP = 1'b1; EXP_A = 8'd129; EXP_B = 8'd128;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_wins_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("rst_wins_idle", {62'd0, busy, done}, 64'd0);

    // random operands, sometimes back-to-back
    for (int i = 0; i < 150; i++) begin
      m = 1'($urandom);
      issue(m, 1'($urandom), 1'($urandom), rexp(m), rexp(m), rmant(), rmant());
      wait_done("rand");
      if ($urandom_range(3) != 0) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
